reg_file_param: RTL



---
 rtl/reg_file_param.sv | 104 ++++++++++
 1 files changed

// File: rtl/reg_file_param.sv
// Parametrised register file: DEPTH x WIDTH storage, byte-enabled write port, two combinational read ports.
// Optional write-to-read forwarding is built when REG_FILE_BYPASS_EN is defined.
module reg_file_param #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned AW      = 5,
    parameter bit          ZERO_R0 = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [WIDTH/8-1:0]   wr_be,
    input  logic [WIDTH-1:0]     in,
    input  logic [AW-1:0]        rd_addr_a,
    input  logic [AW-1:0]        rd_addr_b,
    output logic [WIDTH-1:0]     out_a,
    output logic [WIDTH-1:0]     out_b
);

    localparam int unsigned NB = WIDTH / 8;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             wr_valid_s;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return 32'(a) < 32'(DEPTH);
    endfunction

    // An address is readable storage unless out of range or the hardwired-zero entry.
    function automatic logic addr_live(input logic [AW-1:0] a);
        return addr_ok(a) && !(ZERO_R0 && (a == {AW{1'b0}}));
    endfunction

    function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] a);
        logic [WIDTH-1:0] v;
        v = {WIDTH{1'b0}};
        if (addr_live(a)) begin
            v = mem_q[a];
`ifdef REG_FILE_BYPASS_EN
            if (wr_valid_s && (a == wr_addr)) begin
                for (int k = 0; k < NB; k++) begin
                    if (wr_be[k]) begin
                        v[8*k +: 8] = in[8*k +: 8];
                    end else begin
                        v[8*k +: 8] = mem_q[a][8*k +: 8];
                    end
                end
            end else begin
                v = mem_q[a];
            end
`endif
        end else begin
            v = {WIDTH{1'b0}};
        end
        return v;
    endfunction

    // Qualify the write: reset, out-of-range and zero-entry writes are dropped.
    always_comb begin
        wr_valid_s = wr_en && !rst && addr_live(wr_addr);
    end

    // Next-state storage: byte-lane merge of the write data into the addressed entry.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_valid_s) begin
            for (int k = 0; k < NB; k++) begin
                if (wr_be[k]) begin
                    mem_d[wr_addr][8*k +: 8] = in[8*k +: 8];
                end else begin
                    mem_d[wr_addr][8*k +: 8] = mem_q[wr_addr][8*k +: 8];
                end
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = mem_q[i];
            end
        end
    end

    // Storage flops; reset wins over any same-edge write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Combinational read ports.
    always_comb begin
        out_a = read_port(rd_addr_a);
        out_b = read_port(rd_addr_b);
    end

endmodule
